// File: rtl/dma_if_pkg.sv
// Shared definitions for the DMA interface mux blocks.
// Contents:
//   - DMA status error codes carried on *_status_error
//   - port_width():   index width for a given number of mux ports
//   - credit_width(): counter width able to hold 0..max_out inclusive
package dma_if_pkg;

  localparam logic [3:0] DMA_ERROR_NONE              = 4'd0;
  localparam logic [3:0] DMA_ERROR_TIMEOUT           = 4'd1;
  localparam logic [3:0] DMA_ERROR_PARITY            = 4'd2;
  localparam logic [3:0] DMA_ERROR_AXI_RD_SLVERR     = 4'd4;
  localparam logic [3:0] DMA_ERROR_AXI_RD_DECERR     = 4'd5;
  localparam logic [3:0] DMA_ERROR_PCIE_FLR          = 4'd8;
  localparam logic [3:0] DMA_ERROR_PCIE_CPL_POISONED = 4'd9;

  // Never below 1 so a degenerate single-port build still has a legal vector.
  function automatic int unsigned port_width(input int unsigned ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  function automatic int unsigned credit_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/dma_if_mux_rd_arb.sv
// PORTS-wide request arbiter, round-robin or fixed priority.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_req          per-port request (already qualified by credit)
//   i_en           a grant may be issued this cycle
//   o_grant        one-hot grant, zero when i_en is low or nothing requests
//   o_grant_idx    encoded index of the granted port
//   o_grant_valid  a grant is issued this cycle
module dma_if_mux_rd_arb
  import dma_if_pkg::*;
#(
  parameter int unsigned PORTS                 = 2,
  parameter bit          ARB_TYPE_ROUND_ROBIN  = 1'b1,
  parameter bit          ARB_LSB_HIGH_PRIORITY = 1'b1,
  localparam int unsigned PW                   = port_width(PORTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] i_req,
  input  logic             i_en,
  output logic [PORTS-1:0] o_grant,
  output logic [PW-1:0]    o_grant_idx,
  output logic             o_grant_valid
);

  logic [PW-1:0] r_ptr;
  logic          w_found;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_cand;

  // i-th port in search order.
  function automatic int unsigned cand_port(input int unsigned i, input int unsigned ptr);
    if (ARB_TYPE_ROUND_ROBIN) begin
      return (ptr + i) % PORTS;
    end else if (ARB_LSB_HIGH_PRIORITY) begin
      return i;
    end else begin
      return PORTS - 1 - i;
    end
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      w_cand = PW'(cand_port(i, 32'(r_ptr)));
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (i_en && w_found) begin
      o_grant[w_idx] = 1'b1;
    end
    o_grant_idx   = w_idx;
    o_grant_valid = i_en && w_found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (ARB_TYPE_ROUND_ROBIN && o_grant_valid) begin
      r_ptr <= (w_idx == PW'(PORTS - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dma_if_mux_rd_credit.sv
// N-port DMA read-descriptor mux with per-port outstanding-read credit limits.
// Client descriptors are arbitrated into a single registered output; the port index is
// prefixed onto tag and ram_sel so completion status can be routed back by tag MSBs.
// Each port may have at most MAX_OUTSTANDING reads in flight.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   m_axis_read_desc_*                descriptor to the DMA interface (M widths)
//   s_axis_read_desc_status_*         completion status from the DMA interface (no ready)
//   s_axis_read_desc_*                per-port client descriptors (flattened PORTS*width)
//   m_axis_read_desc_status_*         per-port routed completion status
//   port_outstanding                  live in-flight count per port (PORTS*CW)
//   stat_desc_count, stat_err_count   per-port 32-bit accepted / errored counters,
//                                     present only with DMA_IF_MUX_RD_STATS_EN defined
module dma_if_mux_rd_credit
  import dma_if_pkg::*;
#(
  parameter int unsigned PORTS                 = 2,
  parameter int unsigned DMA_ADDR_WIDTH        = 64,
  parameter int unsigned FUNCTION_ID_WIDTH     = 8,
  parameter int unsigned S_RAM_SEL_WIDTH       = 2,
  parameter int unsigned RAM_ADDR_WIDTH        = 16,
  parameter int unsigned LEN_WIDTH             = 16,
  parameter int unsigned S_TAG_WIDTH           = 8,
  parameter int unsigned MAX_OUTSTANDING       = 16,
  parameter bit          ARB_TYPE_ROUND_ROBIN  = 1'b1,
  parameter bit          ARB_LSB_HIGH_PRIORITY = 1'b1,
  localparam int unsigned PW                   = port_width(PORTS),
  localparam int unsigned CW                   = credit_width(MAX_OUTSTANDING),
  localparam int unsigned M_RAM_SEL_WIDTH      = S_RAM_SEL_WIDTH + PW,
  localparam int unsigned M_TAG_WIDTH          = S_TAG_WIDTH + PW
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  // Descriptor to DMA interface
  output logic [DMA_ADDR_WIDTH-1:0]            m_axis_read_desc_dma_addr,
  output logic [FUNCTION_ID_WIDTH-1:0]         m_axis_read_desc_function_id,
  output logic [M_RAM_SEL_WIDTH-1:0]           m_axis_read_desc_ram_sel,
  output logic [RAM_ADDR_WIDTH-1:0]            m_axis_read_desc_ram_addr,
  output logic [LEN_WIDTH-1:0]                 m_axis_read_desc_len,
  output logic [M_TAG_WIDTH-1:0]               m_axis_read_desc_tag,
  output logic                                 m_axis_read_desc_valid,
  input  logic                                 m_axis_read_desc_ready,
  // Status from DMA interface
  input  logic [M_TAG_WIDTH-1:0]               s_axis_read_desc_status_tag,
  input  logic [3:0]                           s_axis_read_desc_status_error,
  input  logic                                 s_axis_read_desc_status_valid,
  // Client descriptors
  input  logic [PORTS*DMA_ADDR_WIDTH-1:0]      s_axis_read_desc_dma_addr,
  input  logic [PORTS*FUNCTION_ID_WIDTH-1:0]   s_axis_read_desc_function_id,
  input  logic [PORTS*S_RAM_SEL_WIDTH-1:0]     s_axis_read_desc_ram_sel,
  input  logic [PORTS*RAM_ADDR_WIDTH-1:0]      s_axis_read_desc_ram_addr,
  input  logic [PORTS*LEN_WIDTH-1:0]           s_axis_read_desc_len,
  input  logic [PORTS*S_TAG_WIDTH-1:0]         s_axis_read_desc_tag,
  input  logic [PORTS-1:0]                     s_axis_read_desc_valid,
  output logic [PORTS-1:0]                     s_axis_read_desc_ready,
  // Routed client status
  output logic [PORTS*S_TAG_WIDTH-1:0]         m_axis_read_desc_status_tag,
  output logic [PORTS*4-1:0]                   m_axis_read_desc_status_error,
  output logic [PORTS-1:0]                     m_axis_read_desc_status_valid,
`ifdef DMA_IF_MUX_RD_STATS_EN
  output logic [PORTS*32-1:0]                  stat_desc_count,
  output logic [PORTS*32-1:0]                  stat_err_count,
`endif
  output logic [PORTS*CW-1:0]                  port_outstanding
);

  // ---------------------------------------------------------------------------
  // Arbitration with credit qualification
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    r_cnt [PORTS];
  logic [PORTS-1:0] w_elig;
  logic [PORTS-1:0] w_grant;
  logic [PW-1:0]    w_grant_idx;
  logic             w_grant_valid;
  logic             w_load;
  logic [31:0]      w_sel;
  logic             r_m_valid;

  always_comb begin
    w_elig = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_elig[p] = s_axis_read_desc_valid[p] && (r_cnt[p] < CW'(MAX_OUTSTANDING));
    end
  end

  // The holding register can take a new descriptor when empty or draining this cycle.
  assign w_load = !r_m_valid || m_axis_read_desc_ready;
  assign w_sel  = 32'(w_grant_idx);

  dma_if_mux_rd_arb #(
    .PORTS                (PORTS),
    .ARB_TYPE_ROUND_ROBIN (ARB_TYPE_ROUND_ROBIN),
    .ARB_LSB_HIGH_PRIORITY(ARB_LSB_HIGH_PRIORITY)
  ) u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (w_elig),
    .i_en         (w_load),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_grant_valid(w_grant_valid)
  );

  assign s_axis_read_desc_ready = w_grant;

  // ---------------------------------------------------------------------------
  // Output holding register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid                    <= 1'b0;
      m_axis_read_desc_dma_addr    <= '0;
      m_axis_read_desc_function_id <= '0;
      m_axis_read_desc_ram_sel     <= '0;
      m_axis_read_desc_ram_addr    <= '0;
      m_axis_read_desc_len         <= '0;
      m_axis_read_desc_tag         <= '0;
    end else if (w_grant_valid) begin
      r_m_valid                    <= 1'b1;
      m_axis_read_desc_dma_addr    <= s_axis_read_desc_dma_addr[w_sel*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
      m_axis_read_desc_function_id <=
        s_axis_read_desc_function_id[w_sel*FUNCTION_ID_WIDTH +: FUNCTION_ID_WIDTH];
      m_axis_read_desc_ram_sel     <=
        {w_grant_idx, s_axis_read_desc_ram_sel[w_sel*S_RAM_SEL_WIDTH +: S_RAM_SEL_WIDTH]};
      m_axis_read_desc_ram_addr    <= s_axis_read_desc_ram_addr[w_sel*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
      m_axis_read_desc_len         <= s_axis_read_desc_len[w_sel*LEN_WIDTH +: LEN_WIDTH];
      m_axis_read_desc_tag         <=
        {w_grant_idx, s_axis_read_desc_tag[w_sel*S_TAG_WIDTH +: S_TAG_WIDTH]};
    end else if (m_axis_read_desc_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_axis_read_desc_valid = r_m_valid;

  // ---------------------------------------------------------------------------
  // Status decode, credit counters, status demux
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    w_st_port;
  logic             w_st_hit;
  logic [PORTS-1:0] w_st_onehot;

  assign w_st_port = s_axis_read_desc_status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH];
  // Statuses addressed beyond the last port are dropped entirely.
  assign w_st_hit  = s_axis_read_desc_status_valid && (32'(w_st_port) < PORTS);

  always_comb begin
    w_st_onehot = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_st_onehot[p] = w_st_hit && (w_st_port == PW'(p));
    end
  end

  // Simultaneous accept and status cancel; a stale status at zero saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PORTS; p++) begin
        r_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        case ({w_grant[p], w_st_onehot[p]})
          2'b10:   r_cnt[p] <= r_cnt[p] + 1'b1;
          2'b01:   if (r_cnt[p] != '0) r_cnt[p] <= r_cnt[p] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  logic [PORTS-1:0]       r_st_valid;
  logic [S_TAG_WIDTH-1:0] r_st_tag [PORTS];
  logic [3:0]             r_st_err [PORTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_valid <= '0;
      for (int p = 0; p < PORTS; p++) begin
        r_st_tag[p] <= '0;
        r_st_err[p] <= '0;
      end
    end else begin
      r_st_valid <= w_st_onehot;
      for (int p = 0; p < PORTS; p++) begin
        if (w_st_onehot[p]) begin
          r_st_tag[p] <= s_axis_read_desc_status_tag[S_TAG_WIDTH-1:0];
          r_st_err[p] <= s_axis_read_desc_status_error;
        end
      end
    end
  end

  always_comb begin
    m_axis_read_desc_status_tag   = '0;
    m_axis_read_desc_status_error = '0;
    port_outstanding              = '0;
    for (int p = 0; p < PORTS; p++) begin
      m_axis_read_desc_status_tag[p*S_TAG_WIDTH +: S_TAG_WIDTH] = r_st_tag[p];
      m_axis_read_desc_status_error[p*4 +: 4]                   = r_st_err[p];
      port_outstanding[p*CW +: CW]                              = r_cnt[p];
    end
  end

  assign m_axis_read_desc_status_valid = r_st_valid;

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef DMA_IF_MUX_RD_STATS_EN
  logic [31:0] r_stat_desc [PORTS];
  logic [31:0] r_stat_err  [PORTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PORTS; p++) begin
        r_stat_desc[p] <= '0;
        r_stat_err[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (w_grant[p]) begin
          r_stat_desc[p] <= r_stat_desc[p] + 32'd1;
        end
        if (w_st_onehot[p] && (s_axis_read_desc_status_error != DMA_ERROR_NONE)) begin
          r_stat_err[p] <= r_stat_err[p] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    stat_desc_count = '0;
    stat_err_count  = '0;
    for (int p = 0; p < PORTS; p++) begin
      stat_desc_count[p*32 +: 32] = r_stat_desc[p];
      stat_err_count[p*32 +: 32]  = r_stat_err[p];
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_dma_if_mux_rd_credit.sv
// Self-checking bench for dma_if_mux_rd_credit: PORTS=2, MAX_OUTSTANDING=4, round robin.
module tb_dma_if_mux_rd_credit;

  localparam int P    = 2;
  localparam int MAXO = 4;
  localparam int CW   = 3;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  fid;
    logic [2:0]  rs;
    logic [15:0] raddr;
    logic [15:0] len;
    logic [8:0]  tag;
  } desc_t;

  logic         clk;
  logic         rst_n;
  logic [63:0]  m_addr;
  logic [7:0]   m_fid;
  logic [2:0]   m_rs;
  logic [15:0]  m_raddr;
  logic [15:0]  m_len;
  logic [8:0]   m_tag;
  logic         m_valid;
  logic         m_ready;
  logic [8:0]   st_tag_in;
  logic [3:0]   st_err_in;
  logic         st_valid_in;
  logic [127:0] s_addr;
  logic [15:0]  s_fid;
  logic [3:0]   s_rs;
  logic [31:0]  s_raddr;
  logic [31:0]  s_len;
  logic [15:0]  s_tag;
  logic [1:0]   s_valid;
  logic [1:0]   s_ready;
  logic [15:0]  m_st_tag;
  logic [7:0]   m_st_err;
  logic [1:0]   m_st_valid;
  logic [5:0]   outst;
`ifdef DMA_IF_MUX_RD_STATS_EN
  logic [63:0]  stat_desc;
  logic [63:0]  stat_err;
`endif

  int    n_cmp = 0;
  int    n_err = 0;
  desc_t exp_q[$];
  int    grant_log[$];
  int    model_cnt [P];
  logic [1:0] exp_sv;
  logic [7:0] exp_st_tag;
  logic [3:0] exp_st_err;

  dma_if_mux_rd_credit #(
    .PORTS          (P),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .m_axis_read_desc_dma_addr    (m_addr),
    .m_axis_read_desc_function_id (m_fid),
    .m_axis_read_desc_ram_sel     (m_rs),
    .m_axis_read_desc_ram_addr    (m_raddr),
    .m_axis_read_desc_len         (m_len),
    .m_axis_read_desc_tag         (m_tag),
    .m_axis_read_desc_valid       (m_valid),
    .m_axis_read_desc_ready       (m_ready),
    .s_axis_read_desc_status_tag  (st_tag_in),
    .s_axis_read_desc_status_error(st_err_in),
    .s_axis_read_desc_status_valid(st_valid_in),
    .s_axis_read_desc_dma_addr    (s_addr),
    .s_axis_read_desc_function_id (s_fid),
    .s_axis_read_desc_ram_sel     (s_rs),
    .s_axis_read_desc_ram_addr    (s_raddr),
    .s_axis_read_desc_len         (s_len),
    .s_axis_read_desc_tag         (s_tag),
    .s_axis_read_desc_valid       (s_valid),
    .s_axis_read_desc_ready       (s_ready),
    .m_axis_read_desc_status_tag  (m_st_tag),
    .m_axis_read_desc_status_error(m_st_err),
    .m_axis_read_desc_status_valid(m_st_valid),
`ifdef DMA_IF_MUX_RD_STATS_EN
    .stat_desc_count              (stat_desc),
    .stat_err_count               (stat_err),
`endif
    .port_outstanding             (outst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int p, input logic [7:0] tag, input logic [1:0] rs);
    s_valid[p]           = 1'b1;
    s_tag[p*8 +: 8]      = tag;
    s_rs[p*2 +: 2]       = rs;
    s_addr[p*64 +: 64]   = {32'hA5A5_0000, 16'(p), 8'h00, tag};
    s_fid[p*8 +: 8]      = tag ^ 8'h3C;
    s_raddr[p*16 +: 16]  = {tag, 8'(p)};
    s_len[p*16 +: 16]    = {8'h01, tag};
  endtask

  task automatic send_status(input logic [8:0] tag, input logic [3:0] err);
    st_valid_in = 1'b1;
    st_tag_in   = tag;
    st_err_in   = err;
    step();
    st_valid_in = 1'b0;
  endtask

  // Monitor: sample mid-cycle, check what the DUT shows now, then record what the
  // coming clock edge should produce.
  always @(negedge clk) begin : mon
    desc_t e;
    logic  acc;
    logic  hit;
    if (!rst_n) begin
      exp_q.delete();
      for (int p = 0; p < P; p++) model_cnt[p] = 0;
      exp_sv = '0;
    end else begin
      if (m_valid && m_ready) begin
        check("sb_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("desc_tag", m_tag, e.tag);
          check("desc_ram_sel", m_rs, e.rs);
          check("desc_addr", m_addr, e.addr);
          check("desc_fid", m_fid, e.fid);
          check("desc_ram_addr", m_raddr, e.raddr);
          check("desc_len", m_len, e.len);
        end
      end
      check("ready_onehot", $onehot0(s_ready), 1'b1);
      for (int p = 0; p < P; p++) begin
        check("outstanding", outst[p*CW +: CW], model_cnt[p]);
        if (model_cnt[p] >= MAXO) check("ready_at_cap", s_ready[p], 1'b0);
      end
      if (exp_sv != 0 || m_st_valid != 0) check("st_valid", m_st_valid, exp_sv);
      for (int p = 0; p < P; p++) begin
        if (exp_sv[p]) begin
          check("st_tag", m_st_tag[p*8 +: 8], exp_st_tag);
          check("st_err", m_st_err[p*4 +: 4], exp_st_err);
        end
      end
      exp_sv = '0;
      for (int p = 0; p < P; p++) begin
        acc = s_valid[p] && s_ready[p];
        hit = st_valid_in && (st_tag_in[8] == 1'(p));
        if (acc) begin
          e.tag   = {1'(p), s_tag[p*8 +: 8]};
          e.rs    = {1'(p), s_rs[p*2 +: 2]};
          e.addr  = s_addr[p*64 +: 64];
          e.fid   = s_fid[p*8 +: 8];
          e.raddr = s_raddr[p*16 +: 16];
          e.len   = s_len[p*16 +: 16];
          exp_q.push_back(e);
          grant_log.push_back(p);
        end
        if (acc && !hit) model_cnt[p]++;
        else if (hit && !acc && model_cnt[p] > 0) model_cnt[p]--;
        if (hit) begin
          exp_sv[p]  = 1'b1;
          exp_st_tag = st_tag_in[7:0];
          exp_st_err = st_err_in;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;  m_ready = 1'b1;
    st_tag_in = '0; st_err_in = '0; st_valid_in = 1'b0;
    s_addr = '0; s_fid = '0; s_rs = '0; s_raddr = '0; s_len = '0; s_tag = '0; s_valid = '0;
    #2;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_tag", m_tag, 9'h000);
    check("rst_outstanding", outst, 6'h00);
    check("rst_st_valid", m_st_valid, 2'b00);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Port prefixing onto tag and ram_sel, one-cycle latency.
    set_desc(0, 8'h05, 2'b01);
    step();
    s_valid[0] = 1'b0;
    set_desc(1, 8'h05, 2'b01);
    check("p0_valid", m_valid, 1'b1);
    check("p0_tag", m_tag, 9'h005);
    check("p0_ram_sel", m_rs, 3'b001);
    step();
    s_valid[1] = 1'b0;
    check("p1_tag", m_tag, 9'h105);
    check("p1_ram_sel", m_rs, 3'b101);
    step();
    send_status(9'h005, 4'h0);
    send_status(9'h105, 4'h0);
    check("st_route_p1", m_st_valid, 2'b10);

    // Round robin with both ports requesting continuously.
    grant_log.delete();
    set_desc(0, 8'h20, 2'b00);
    set_desc(1, 8'h30, 2'b10);
    repeat (4) step();
    s_valid = '0;
    step();
    check("rr_count", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size(); i++) check("rr_order", grant_log[i], i % 2);
    send_status(9'h020, 4'h0);
    send_status(9'h020, 4'h0);
    send_status(9'h130, 4'h0);
    send_status(9'h130, 4'h0);

    // Credit cap on port 0.
    set_desc(0, 8'h40, 2'b01);
    repeat (5) step();
    check("cap_ready", s_ready[0], 1'b0);
    check("cap_count", outst[2:0], 3'd4);
    send_status(9'h040, 4'h0);
    check("credit_ready", s_ready[0], 1'b1);
    check("credit_count", outst[2:0], 3'd3);
    step();
    s_valid[0] = 1'b0;
    step();
    repeat (4) send_status(9'h040, 4'h0);

    // Same-cycle accept and status on port 1.
    set_desc(1, 8'h50, 2'b00);
    step();
    s_valid[1] = 1'b0;
    step();
    set_desc(1, 8'h51, 2'b01);
    st_valid_in = 1'b1; st_tag_in = 9'h1A3; st_err_in = 4'h0;
    step();
    s_valid[1] = 1'b0; st_valid_in = 1'b0;
    check("same_cycle_count", outst[5:3], 3'd1);
    check("st_1a3_valid", m_st_valid, 2'b10);
    check("st_1a3_tag", m_st_tag[15:8], 8'hA3);
    check("st_1a3_err", m_st_err[7:4], 4'h0);
    step();
    send_status(9'h100, 4'h0);

    // Back-pressure hold, then reset mid-hold.
    m_ready = 1'b0;
    set_desc(0, 8'h44, 2'b10);
    step();
    set_desc(0, 8'h45, 2'b11);
    set_desc(1, 8'h46, 2'b00);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", m_valid, 1'b1);
      check("hold_tag", m_tag, 9'h044);
      check("hold_addr", m_addr, 64'hA5A5_0000_0000_0044);
      check("hold_ready", s_ready, 2'b00);
      step();
    end
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", m_valid, 1'b0);
    check("rst_hold_count", outst, 6'h00);
    s_valid = '0;
    m_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Stale status after reset saturates but is still forwarded.
    send_status(9'h0AB, 4'h0);
    check("stale_valid", m_st_valid, 2'b01);
    check("stale_tag", m_st_tag[7:0], 8'hAB);
    check("stale_count", outst[2:0], 3'd0);

    // Three descriptors and one errored status on port 0.
    for (int i = 0; i < 3; i++) begin
      set_desc(0, 8'(8'h60 + i), 2'b00);
      step();
    end
    s_valid[0] = 1'b0;
    step();
    send_status(9'h060, 4'h4);
    step();
    check("after_err_count", outst[2:0], 3'd2);
`ifdef DMA_IF_MUX_RD_STATS_EN
    check("stat_desc_p0", stat_desc[31:0], 32'd3);
    check("stat_err_p0", stat_err[31:0], 32'd1);
    check("stat_desc_p1", stat_desc[63:32], 32'd0);
    check("stat_err_p1", stat_err[63:32], 32'd0);
`endif
    step();
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
